vga_scanout_fifo: RTL
=====================

Name: vga_scanout_fifo

Overview:
- Downstream neighbour of the SDRAM reader/writer.
- Accepts burst read dwords returned by the SDRAM controller for the 1280x720 framebuffer and buffers them in a dword FIFO.
- Reports a quantised 2-bit fill level back to the reader so it can throttle read requests.
- Unpacks each dword into two RGB565 pixels and delivers them to the VGA timing/output stage on demand.
- Detects and flags overflow, underflow and frame misalignment.

Parameters:
- AW, 9: FIFO address width; depth = 2**AW dwords (512).
- PIX_PER_FRAME, 921600: 1280*720 visible pixels per frame.

Ports:
- mem_clk  input  1  single clock for all logic.
- reset  input  1  synchronous, active-low reset (0 = reset).
- rd_data  input  32  SDRAM read dword; low half is the first pixel.
- rd_data_valid  input  1  rd_data valid this cycle.
- fifo_level  output  2  quantised fill level for the reader's thresholds.
- pix_req  input  1  timing stage consumes one pixel this cycle.
- frame_start  input  1  one-cycle pulse, coincident with pix_req of the first visible pixel.
- pix_r  output  5  red.
- pix_g  output  6  green.
- pix_b  output  5  blue.
- pix_valid  output  1  registered pixel is real data (0 = black substituted).
- clr_flags  input  1  clears the sticky flags.
- overflow  output  1  sticky: a dword was dropped because the FIFO was full.
- underflow  output  1  sticky: pix_req arrived with no data available.
- sync_err  output  1  sticky: frame_start arrived with pixel counter != 0.

Behaviour:
- Reset (reset==0 at a clock edge): pointers, used count, half-select, prefetch register, pixel counter cleared; buffered data discarded. All outputs 0: fifo_level=0, pix_*=0, pix_valid=0, flags=0. Reset mid-burst drops the remainder; beats arriving during reset are ignored.
- Storage: inferred simple dual-port RAM, 1-cycle registered read. used counter is AW+1 bits, range 0..2**AW.
- Write: on rd_data_valid with used<2**AW, store and increment wptr. On rd_data_valid while full, drop the beat and set overflow. wptr wraps modulo 2**AW.
- fifo_level: registered one cycle after used changes. If used==2**AW then 2'b11, else used[AW-1:AW-2]. Quartiles are 0-127, 128-255, 256-383, 384-512.
- Prefetch: one 32-bit output word register with a valid bit and a half-select bit. When the register is empty, or being emptied this cycle, and the RAM is non-empty, issue a RAM read; the register loads on the next cycle.
- First-word latency: a dword written into an empty FIFO at cycle T is consumable by pix_req at T+2.
- pix_req with the word valid:
  - Pixel output registered at the next edge (latency 1).
  - half=0 outputs bits 15:0; half=1 outputs bits 31:16, then frees the word.
  - Mapping: r=[15:11], g=[10:5], b=[4:0]; pix_valid=1.
- pix_req with no word valid: outputs 0 with pix_valid=0, set underflow. Half-select does not advance and no data is skipped.
- No pix_req: pixel outputs hold their last value; pix_valid drops to 0.
- Simultaneous write and read: used unchanged. Write into full concurrent with a pop still drops the beat; full is evaluated at the start of the cycle.
- Pixel counter:
  - Counts pix_req cycles, including underflowed ones, wrapping at PIX_PER_FRAME-1 to 0.
  - frame_start with counter!=0 sets sync_err and forces the counter to 1.
  - frame_start with counter==0 advances normally.
- Flags: clr_flags clears them the next cycle. A set event in the same cycle as clr_flags wins.

Decomposition:
- Shared package: RGB565 field positions, LEVEL_* encodings (2'b00..2'b11), PIX_PER_FRAME for 1280x720.
- One sub-module: scanout_dpram, a parameterised simple dual-port RAM (AW, 32-bit, registered read), so the Quartus megafunction can be swapped in.
- Prefetch, level and flag logic stay in the top.

Test Plan:
- Reset: release, write 1 dword 0x1234ABCD at T. pix_req at T+2, T+3 -> outputs {r,g,b} from 0xABCD then 0x1234, pix_valid=1 both; fifo_level returns to 0.
- Level quantisation: write 128 dwords, no reads -> fifo_level 2'b01. Write 256 -> 2'b10. Write 512 -> 2'b11. Write a 513th -> dropped, overflow=1, level stays 2'b11.
- Underflow: empty FIFO, pix_req 3 cycles -> pix_valid=0, pixels 0, underflow=1. Then write 0x00FF0F0F -> next two pix_req yield 0x0F0F then 0x00FF; no pixel lost.
- Concurrent: 8-beat bursts while pix_req runs continuously at 1 pixel/cycle with the FIFO at 200 dwords -> output pixel sequence equals input halves in order; no flags set.
- Frame sync: frame_start after 1000 pixels -> sync_err=1, counter=1. clr_flags -> sync_err=0. frame_start after exactly PIX_PER_FRAME pixels -> no error.
- Mid-operation reset: assert reset during a burst with 300 dwords buffered -> fifo_level=0 and pix_valid=0 next cycle; the post-reset first word is output correctly.

Source files
------------

// File: rtl/vga_scanout_fifo_pkg.sv
// Shared constants and types for the VGA scanout FIFO: RGB565 field
// positions, quantised fill-level encodings and 720p frame geometry.
package vga_scanout_fifo_pkg;

  // RGB565 layout inside one 16-bit pixel half of a framebuffer dword.
  localparam int R_MSB = 15;
  localparam int R_LSB = 11;
  localparam int G_MSB = 10;
  localparam int G_LSB = 5;
  localparam int B_MSB = 4;
  localparam int B_LSB = 0;

  // Visible framebuffer geometry.
  localparam int H_VISIBLE          = 1280;
  localparam int V_VISIBLE          = 720;
  localparam int PIX_PER_FRAME_720P = H_VISIBLE * V_VISIBLE;

  // Quartile of the FIFO fill reported back to the SDRAM reader.
  typedef enum logic [1:0] {
    LEVEL_Q0 = 2'b00,
    LEVEL_Q1 = 2'b01,
    LEVEL_Q2 = 2'b10,
    LEVEL_Q3 = 2'b11
  } level_e;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  // Split one RGB565 pixel into its colour fields.
  function automatic rgb565_t unpack_rgb565(input logic [15:0] p);
    rgb565_t c;
    c.r = p[R_MSB:R_LSB];
    c.g = p[G_MSB:G_LSB];
    c.b = p[B_MSB:B_LSB];
    return c;
  endfunction

endpackage

// File: rtl/vga_scanout_fifo_if.sv
// Bus bundle between the SDRAM reader, the scanout FIFO and the VGA
// timing stage.
//
// Handshake semantics: rd_data is captured on every clock edge where
// rd_data_valid is high; there is no ready, the reader throttles itself
// from fifo_level and a beat arriving while full is dropped. pix_req high
// at an edge consumes exactly one pixel; the pixel appears on pix_r/g/b
// one edge later with pix_valid marking whether it is real data.
interface vga_scanout_fifo_if;

  logic [31:0] rd_data;
  logic        rd_data_valid;
  logic [1:0]  fifo_level;
  logic        pix_req;
  logic        frame_start;
  logic [4:0]  pix_r;
  logic [5:0]  pix_g;
  logic [4:0]  pix_b;
  logic        pix_valid;

  // Environment side: SDRAM reader plus VGA timing stage.
  modport master (
    output rd_data, rd_data_valid, pix_req, frame_start,
    input  fifo_level, pix_r, pix_g, pix_b, pix_valid
  );

  // FIFO side.
  modport slave (
    input  rd_data, rd_data_valid, pix_req, frame_start,
    output fifo_level, pix_r, pix_g, pix_b, pix_valid
  );

endinterface

// File: rtl/vga_scanout_fifo_dpram.sv
// Simple dual-port RAM with a registered read port. Kept as a separate
// module so a vendor RAM block can replace it without touching the FIFO.
// The read register holds its value when rd_en is low.
module scanout_dpram #(
  parameter int AW = 9,
  parameter int DW = 32
) (
  input  logic          mem_clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [2**AW];

  // Write port.
  always_ff @(posedge mem_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port; doubles as the FIFO's prefetch word.
  always_ff @(posedge mem_clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/vga_scanout_fifo.sv
// Dword FIFO between the SDRAM reader and the VGA output stage. Buffers
// burst read data, reports a quantised fill level, unpacks each dword into
// two RGB565 pixels (low half first) and tracks frame alignment.
//
// The RAM read register serves as the prefetch word: a read is issued as
// soon as that word is empty or being freed, so a dword written into an
// empty FIFO is consumable two cycles later. 'used' counts every dword
// held, including the one sitting in the prefetch word.
module vga_scanout_fifo
  import vga_scanout_fifo_pkg::*;
#(
  parameter int AW            = 9,
  parameter int PIX_PER_FRAME = PIX_PER_FRAME_720P
) (
  input  logic                             mem_clk,
  input  logic                             reset,
  vga_scanout_fifo_if.slave                bus,
  input  logic                             clr_flags,
  output logic                             overflow,
  output logic                             underflow,
  output logic                             sync_err,
  output logic [$clog2(PIX_PER_FRAME)-1:0] pix_cnt
);

  localparam int DEPTH = 2**AW;
  localparam int CW    = $clog2(PIX_PER_FRAME);

  logic [AW:0]   used;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          word_valid;
  logic          half;
  logic [31:0]   word;

  logic          full;
  logic          ram_has;
  logic          wr_fire;
  logic          pix_take;
  logic          pop_word;
  logic          rd_issue;
  logic [15:0]   half_px;
  rgb565_t       px;
  level_e        level_d;
  level_e        level_q;

  logic [4:0]    pix_r_q;
  logic [5:0]    pix_g_q;
  logic [4:0]    pix_b_q;
  logic          pix_valid_q;

  logic [CW-1:0] cnt;
  logic          cnt_wrap;
  logic          sync_hit;
  logic          ovf_set;
  logic          unf_set;
  logic          overflow_q;
  logic          underflow_q;
  logic          sync_err_q;

  // Storage.
  scanout_dpram #(.AW(AW), .DW(32)) u_ram (
    .mem_clk (mem_clk),
    .wr_en   (wr_fire & reset),
    .wr_addr (wptr),
    .wr_data (bus.rd_data),
    .rd_en   (rd_issue & reset),
    .rd_addr (rptr),
    .rd_data (word)
  );

  // Per-cycle FIFO decisions, all taken from start-of-cycle state.
  always_comb begin
    full     = (used == (AW+1)'(DEPTH));
    ram_has  = (used > (AW+1)'(word_valid));
    wr_fire  = bus.rd_data_valid & ~full;
    pix_take = bus.pix_req & word_valid;
    pop_word = pix_take & half;
    rd_issue = ram_has & (~word_valid | pop_word);
    half_px  = half ? word[31:16] : word[15:0];
    px       = unpack_rgb565(half_px);
    level_d  = full ? LEVEL_Q3 : level_e'(used[AW-1:AW-2]);
    sync_hit = bus.frame_start & (cnt != '0);
    cnt_wrap = (cnt == CW'(PIX_PER_FRAME - 1));
    ovf_set  = bus.rd_data_valid & full;
    unf_set  = bus.pix_req & ~word_valid;
  end

  // Pointers, occupancy and prefetch word state.
  always_ff @(posedge mem_clk) begin
    if (!reset) begin
      wptr       <= '0;
      rptr       <= '0;
      used       <= '0;
      word_valid <= 1'b0;
      half       <= 1'b0;
    end else begin
      if (wr_fire)  wptr <= wptr + AW'(1);
      if (rd_issue) rptr <= rptr + AW'(1);
      used <= used + (AW+1)'(wr_fire) - (AW+1)'(pop_word);
      if (rd_issue)      word_valid <= 1'b1;
      else if (pop_word) word_valid <= 1'b0;
      if (pix_take) half <= ~half;
    end
  end

  // Quantised fill level, one cycle behind the occupancy count.
  always_ff @(posedge mem_clk) begin
    if (!reset) level_q <= LEVEL_Q0;
    else        level_q <= level_d;
  end

  // Pixel output register; black with pix_valid low when starved.
  always_ff @(posedge mem_clk) begin
    if (!reset) begin
      pix_r_q     <= '0;
      pix_g_q     <= '0;
      pix_b_q     <= '0;
      pix_valid_q <= 1'b0;
    end else if (bus.pix_req) begin
      if (word_valid) begin
        pix_r_q     <= px.r;
        pix_g_q     <= px.g;
        pix_b_q     <= px.b;
        pix_valid_q <= 1'b1;
      end else begin
        pix_r_q     <= '0;
        pix_g_q     <= '0;
        pix_b_q     <= '0;
        pix_valid_q <= 1'b0;
      end
    end else begin
      pix_valid_q <= 1'b0;
    end
  end

  // Pixel position within the frame; realigns on a misplaced frame_start.
  always_ff @(posedge mem_clk) begin
    if (!reset)           cnt <= '0;
    else if (sync_hit)    cnt <= CW'(1);
    else if (bus.pix_req) cnt <= cnt_wrap ? '0 : cnt + CW'(1);
  end

  // Sticky error flags; a set event beats a simultaneous clear.
  always_ff @(posedge mem_clk) begin
    if (!reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      overflow_q  <= ovf_set  | (overflow_q  & ~clr_flags);
      underflow_q <= unf_set  | (underflow_q & ~clr_flags);
      sync_err_q  <= sync_hit | (sync_err_q  & ~clr_flags);
    end
  end

  assign bus.fifo_level = level_q;
  assign bus.pix_r      = pix_r_q;
  assign bus.pix_g      = pix_g_q;
  assign bus.pix_b      = pix_b_q;
  assign bus.pix_valid  = pix_valid_q;
  assign overflow       = overflow_q;
  assign underflow      = underflow_q;
  assign sync_err       = sync_err_q;
  assign pix_cnt        = cnt;

endmodule
